// File: rtl/memstream_cfg_loader.sv
// Memstream config-port initiator: streams write beats into the config RAM and
// streams words read back from it through a readback FIFO that is never overrun.
module memstream_cfg_loader #(
  parameter int SETS     = 1,
  parameter int DEPTH    = 512,
  parameter int WIDTH    = 32,
  parameter int RB_DEPTH = 8
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             cmd_vld,
  output logic             cmd_rdy,
  input  logic             cmd_op,
  input  logic [31:0]      cmd_addr,
  input  logic [15:0]      cmd_len,
  input  logic [WIDTH-1:0] wdat,
  input  logic             wvld,
  output logic             wrdy,
  output logic [WIDTH-1:0] rdat,
  output logic             rvld,
  input  logic             rrdy,
  output logic [31:0]      config_address,
  output logic             config_ce,
  output logic             config_we,
  output logic [WIDTH-1:0] config_d0,
  input  logic [WIDTH-1:0] config_q0,
  input  logic             config_rack,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_e;

  localparam int          AW      = (RB_DEPTH > 1) ? $clog2(RB_DEPTH) : 1;
  localparam logic [32:0] LIMIT   = 33'(SETS) * 33'(DEPTH);
  localparam logic [AW:0] CAP     = (AW+1)'(RB_DEPTH);
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  state_e             state_q, state_d;
  logic [31:0]        addr_q, addr_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [AW:0]        out_q, out_d;
  logic [AW:0]        fcnt_q, fcnt_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic               ce_q, ce_d;
  logic               we_q, we_d;
  logic [31:0]        caddr_q, caddr_d;
  logic [WIDTH-1:0]   d0_q, d0_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [WIDTH-1:0]   fifo_mem [RB_DEPTH];

  logic [32:0] end_addr;
  logic        rack_ok, push, pop, room, issue;

  assign end_addr = {1'b0, cmd_addr} + {17'd0, cmd_len};
  assign rack_ok  = config_rack && (out_q != '0);
  assign push     = rack_ok;
  assign pop      = (fcnt_q != '0) && rrdy;
  // In-flight requests already own a FIFO slot, so the pair together must stay below capacity.
  assign room     = ({1'b0, out_q} + {1'b0, fcnt_q}) < {1'b0, CAP};
  assign issue    = (state_q == S_READ) && (cnt_q != '0) && room;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    ce_d     = 1'b0;
    we_d     = 1'b0;
    caddr_d  = caddr_q;
    d0_d     = d0_q;
    done_d   = 1'b0;
    err_d    = config_rack && (out_q == '0);
    out_d    = out_q;
    fcnt_d   = fcnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_vld) begin
          if (cmd_len == '0) begin
            done_d = 1'b1;
          end else if (end_addr > LIMIT) begin
            err_d = 1'b1;
          end else begin
            addr_d  = cmd_addr;
            cnt_d   = cmd_len;
            state_d = cmd_op ? S_READ : S_WRITE;
          end
        end
      end
      S_WRITE: begin
        if (wvld) begin
          ce_d    = 1'b1;
          we_d    = 1'b1;
          caddr_d = addr_q;
          d0_d    = wdat;
          addr_d  = addr_q + 32'd1;
          cnt_d   = cnt_q - 16'd1;
          if (cnt_q == 16'd1) state_d = S_DONE;
        end
      end
      S_READ: begin
        if (issue) begin
          ce_d    = 1'b1;
          caddr_d = addr_q;
          addr_d  = addr_q + 32'd1;
          cnt_d   = cnt_q - 16'd1;
          if (cnt_q == 16'd1) state_d = S_DRAIN;
        end
      end
      S_DRAIN: if (out_q == '0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_DONE) done_d = 1'b1;

    case ({issue, rack_ok})
      2'b10:   out_d = out_q + CNT_ONE;
      2'b01:   out_d = out_q - CNT_ONE;
      default: out_d = out_q;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   fcnt_d = fcnt_q + CNT_ONE;
      2'b01:   fcnt_d = fcnt_q - CNT_ONE;
      default: fcnt_d = fcnt_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
      fcnt_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ce_q     <= 1'b0;
      we_q     <= 1'b0;
      caddr_q  <= '0;
      d0_q     <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      fcnt_q   <= fcnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ce_q     <= ce_d;
      we_q     <= we_d;
      caddr_q  <= caddr_d;
      d0_q     <= d0_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // NOTE: FIFO storage is not reset; emptiness lives in fcnt_q and rdat is masked while empty.
  always_ff @(posedge ap_clk) begin
    if (push) fifo_mem[wr_ptr_q] <= config_q0;
  end

  assign cmd_rdy        = (state_q == S_IDLE);
  assign wrdy           = (state_q == S_WRITE);
  assign busy           = (state_q != S_IDLE);
  assign rvld           = (fcnt_q != '0);
  assign rdat           = rvld ? fifo_mem[rd_ptr_q] : '0;
  assign config_ce      = ce_q;
  assign config_we      = we_q;
  assign config_address = caddr_q;
  assign config_d0      = d0_q;
  assign done           = done_q;
  assign err            = err_q;

endmodule

// File: tb/tb_memstream_cfg_loader.sv
// Bench for memstream_cfg_loader: behavioural config RAM with programmable rack
// latency, write/read scoreboards, a command vector table and corner-case sequences.
module tb_memstream_cfg_loader;
  localparam int SETS = 1, DEPTH = 512, WIDTH = 32, RB_DEPTH = 8;

  logic ap_clk = 1'b0, ap_rst_n = 1'b0;
  logic cmd_vld = 1'b0, cmd_op = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [15:0] cmd_len = '0;
  logic [WIDTH-1:0] wdat = '0;
  logic wvld = 1'b0, rrdy = 1'b1;
  logic cmd_rdy, wrdy, rvld, config_ce, config_we, busy, done, err;
  logic [WIDTH-1:0] rdat, config_d0;
  logic [31:0] config_address;
  logic [WIDTH-1:0] config_q0 = '0;
  logic config_rack = 1'b0;

  memstream_cfg_loader #(.SETS(SETS), .DEPTH(DEPTH), .WIDTH(WIDTH), .RB_DEPTH(RB_DEPTH)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdat(wdat), .wvld(wvld), .wrdy(wrdy),
    .rdat(rdat), .rvld(rvld), .rrdy(rrdy),
    .config_address(config_address), .config_ce(config_ce), .config_we(config_we),
    .config_d0(config_d0), .config_q0(config_q0), .config_rack(config_rack),
    .busy(busy), .done(done), .err(err)
  );

  always #5 ap_clk = ~ap_clk;

  int cyc = 0;
  always @(posedge ap_clk) cyc <= cyc + 1;

  int n_vec = 0, n_bad = 0;
  int n_done = 0, n_err = 0, n_wr = 0, n_ce = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  typedef struct { int due; logic [31:0] data; } rep_t;
  wr_t         wr_exp[$];
  logic [31:0] rd_exp[$];
  rep_t        pend[$];

  logic [31:0] mem [DEPTH];
  int rack_lat = 1, tb_out = 0, tb_out_max = 0;
  bit inj_rack = 1'b0, rack_prev = 1'b0;

  initial for (int i = 0; i < DEPTH; i++) mem[i] = 32'hDEAD_0000 | i;

  // Config RAM model: reads reply rack_lat cycles after the request is seen.
  always @(negedge ap_clk) begin
    rep_t r;
    if (rack_prev && tb_out > 0) tb_out--;
    if (config_ce) begin
      n_ce++;
      if (config_we) mem[config_address[8:0]] = config_d0;
      else begin
        tb_out++;
        r.due  = cyc + rack_lat;
        r.data = mem[config_address[8:0]];
        pend.push_back(r);
      end
    end
    if (tb_out > tb_out_max) tb_out_max = tb_out;
    config_rack = 1'b0;
    config_q0   = $urandom;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      r = pend.pop_front();
      config_rack = 1'b1;
      config_q0   = r.data;
    end else if (inj_rack) begin
      config_rack = 1'b1;
      config_q0   = 32'hBAD0_0BAD;
    end
    rack_prev = config_rack;
  end

  // Output monitors
  always @(negedge ap_clk) begin
    wr_t e;
    if (done) n_done++;
    if (err)  n_err++;
    if (config_ce && config_we) begin
      n_wr++;
      if (wr_exp.size() == 0) check("wr_extra", 1, 0);
      else begin
        e = wr_exp.pop_front();
        check("wr_addr", config_address, e.addr);
        check("wr_data", config_d0, e.data);
      end
    end
  end

  logic        hold_pend = 1'b0;
  logic [31:0] hold_dat  = '0;
  always @(negedge ap_clk) begin
    if (hold_pend) check("r_hold", {rvld, rdat}, {1'b1, hold_dat});
    hold_pend = rvld && !rrdy;
    hold_dat  = rdat;
    if (rvld && rrdy) begin
      if (rd_exp.size() == 0) check("rd_extra", 1, 0);
      else check("rdat", rdat, rd_exp.pop_front());
    end
  end

  task automatic check_reset_state();
    check("rst_flags", {cmd_rdy, wrdy, rvld, config_ce, config_we, busy, done, err}, 8'b1000_0000);
    check("rst_addr", config_address, 0);
    check("rst_d0", config_d0, 0);
    check("rst_rdat", rdat, 0);
  endtask

  task automatic send_cmd(input bit op, input logic [31:0] addr, input logic [15:0] len);
    int k;
    @(posedge ap_clk); #1;
    cmd_vld = 1'b1; cmd_op = op; cmd_addr = addr; cmd_len = len;
    for (k = 0; k < 200; k++) begin
      @(negedge ap_clk);
      if (cmd_rdy) break;
    end
    if (k >= 200) check("cmd_accept_timeout", 0, 1);
    @(posedge ap_clk); #1;
    cmd_vld = 1'b0;
  endtask

  task automatic wait_end(input int d0, input int e0);
    int k;
    for (k = 0; k < 3000; k++) begin
      @(negedge ap_clk);
      if (n_done != d0 || n_err != e0) break;
    end
    if (k >= 3000) check("end_timeout", 0, 1);
    repeat (3) @(negedge ap_clk);
  endtask

  task automatic wait_drain();
    int k;
    for (k = 0; k < 1000; k++) begin
      if (rd_exp.size() == 0 && !rvld) break;
      @(negedge ap_clk);
    end
    check("drain_left", rd_exp.size(), 0);
  endtask

  typedef struct {
    bit op; logic [31:0] addr; logic [15:0] len; int lat;
    int exp_done; int exp_err; int exp_ce;
  } vec_t;
  vec_t vecs[$];

  initial begin
    int d0, e0, c0, w0, i, k, cnt;
    vecs = '{
      '{1'b1, 32'd5,          16'd20,  1, 1, 0, 20},
      '{1'b1, 32'd0,          16'd0,   1, 1, 0, 0},
      '{1'b1, 32'd510,        16'd3,   1, 0, 1, 0},
      '{1'b1, 32'd510,        16'd2,   2, 1, 0, 2},
      '{1'b0, 32'd7,          16'd0,   1, 1, 0, 0},
      '{1'b1, 32'd0,          16'd1,   3, 1, 0, 1},
      '{1'b1, 32'hFFFF_FFFF,  16'd2,   1, 0, 1, 0},
      '{1'b1, 32'd0,          16'd513, 1, 0, 1, 0},
      '{1'b0, 32'd600,        16'd1,   1, 0, 1, 0},
      '{1'b1, 32'd100,        16'd9,   3, 1, 0, 9}
    };

    repeat (3) @(posedge ap_clk); #1;
    check_reset_state();
    ap_rst_n = 1'b1;

    // Full-memory write with random valid gaps
    d0 = n_done; e0 = n_err; w0 = n_wr;
    send_cmd(1'b0, 32'd0, 16'(SETS * DEPTH));
    i = 0; k = 0;
    while (i < SETS * DEPTH && k < 5000) begin
      @(posedge ap_clk); #1;
      wvld = ($urandom_range(0, 3) != 0);
      wdat = i;
      @(negedge ap_clk);
      if (wvld && wrdy) begin
        wr_exp.push_back('{32'(i), 32'(i)});
        i++;
      end
      k++;
    end
    @(posedge ap_clk); #1;
    wvld = 1'b0;
    check("wr_beats", i, SETS * DEPTH);
    wait_end(d0, e0);
    check("wr_count", n_wr - w0, SETS * DEPTH);
    check("wr_pending", wr_exp.size(), 0);
    check("wr_done", n_done - d0, 1);
    check("wr_err", n_err - e0, 0);

    // Command table
    foreach (vecs[v]) begin
      rack_lat = vecs[v].lat;
      d0 = n_done; e0 = n_err; c0 = n_ce;
      send_cmd(vecs[v].op, vecs[v].addr, vecs[v].len);
      for (int j = 0; j < vecs[v].exp_ce; j++)
        if (vecs[v].op) rd_exp.push_back(vecs[v].addr + 32'(j));
      wait_end(d0, e0);
      wait_drain();
      check($sformatf("v%0d_done", v), n_done - d0, vecs[v].exp_done);
      check($sformatf("v%0d_err", v), n_err - e0, vecs[v].exp_err);
      check($sformatf("v%0d_ce", v), n_ce - c0, vecs[v].exp_ce);
    end

    // Backpressure: FIFO fills, issue must stop until rrdy returns
    rack_lat = 1;
    @(posedge ap_clk); #1;
    rrdy = 1'b0;
    d0 = n_done; e0 = n_err; c0 = n_ce; tb_out_max = 0;
    send_cmd(1'b1, 32'd200, 16'd64);
    for (int j = 0; j < 64; j++) rd_exp.push_back(32'd200 + 32'(j));
    repeat (50) @(negedge ap_clk);
    check("bp_issued", n_ce - c0, RB_DEPTH);
    check("bp_no_done", n_done - d0, 0);
    @(posedge ap_clk); #1;
    rrdy = 1'b1;
    wait_end(d0, e0);
    wait_drain();
    check("bp_total_ce", n_ce - c0, 64);
    check("bp_done", n_done - d0, 1);
    check("bp_out_max", tb_out_max <= RB_DEPTH, 1);

    // FIFO persists across commands; a spurious rack in IDLE leaves it untouched
    @(posedge ap_clk); #1;
    rrdy = 1'b0;
    d0 = n_done; e0 = n_err; c0 = n_ce;
    send_cmd(1'b1, 32'd300, 16'd2);
    rd_exp.push_back(32'd300); rd_exp.push_back(32'd301);
    wait_end(d0, e0);
    check("persist_rvld", {rvld, cmd_rdy}, 2'b11);
    send_cmd(1'b1, 32'd40, 16'd3);
    for (int j = 0; j < 3; j++) rd_exp.push_back(32'd40 + 32'(j));
    wait_end(d0 + 1, e0);
    check("persist_done", n_done - d0, 2);
    e0 = n_err;
    @(posedge ap_clk); #1;
    inj_rack = 1'b1;
    @(posedge ap_clk); #1;
    inj_rack = 1'b0;
    repeat (3) @(negedge ap_clk);
    check("spur_err", n_err - e0, 1);
    check("persist_ce", n_ce - c0, 5);
    @(posedge ap_clk); #1;
    rrdy = 1'b1;
    wait_drain();

    // Reset with three reads outstanding
    rack_lat = 12;
    d0 = n_done; e0 = n_err;
    send_cmd(1'b1, 32'd5, 16'd20);
    cnt = 0;
    for (k = 0; k < 100 && cnt < 3; k++) begin
      @(posedge ap_clk); #1;
      if (config_ce) cnt++;
    end
    check("rst_issue3", cnt, 3);
    ap_rst_n = 1'b0;
    @(posedge ap_clk); #1;
    check_reset_state();
    ap_rst_n = 1'b1;
    rd_exp.delete();
    repeat (30) @(negedge ap_clk);
    check("late_rack_err", n_err - e0, 3);
    check("abort_no_done", n_done - d0, 0);
    check("abort_fifo_empty", {rvld, busy}, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got no completion, required completion within 2ms");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/memstream_cfg_loader.md
MEMSTREAM_CFG_LOADER -- requirements
Module: memstream_cfg_loader

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  SETS, 1, number of parameter sets in the attached memstream.
  DEPTH, 512, words per set.
  WIDTH, 32, data word width.
  RB_DEPTH, 8, readback FIFO depth; power of 2, at least 2.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  ap_clk, in, 1, sole clock, rising edge.
  ap_rst_n, in, 1, synchronous active-low reset.
  cmd_vld, in, 1, command valid.
  cmd_rdy, out, 1, command ready.
  cmd_op, in, 1, 0=write, 1=read.
  cmd_addr, in, 32, start word address.
  cmd_len, in, 16, word count.
  wdat, in, WIDTH, write data.
  wvld, in, 1, write data valid.
  wrdy, out, 1, write data ready.
  rdat, out, WIDTH, readback data.
  rvld, out, 1, readback data valid.
  rrdy, in, 1, readback data ready.
  config_address, out, 32, memstream config address.
  config_ce, out, 1, config access strobe.
  config_we, out, 1, config write enable.
  config_d0, out, WIDTH, config write data.
  config_q0, in, WIDTH, config read data.
  config_rack, in, 1, read reply valid.
  busy, out, 1, high when state is not IDLE.
  done, out, 1, one-cycle pulse at command completion.
  err, out, 1, one-cycle pulse on a rejected command or a spurious reply.

Function
REQ-003 The block SHALL act as initiator of the memstream config interface: it writes streamed words and reads words back into a stream.
REQ-004 Handshakes on cmd, w and r SHALL be valid/ready: a transfer occurs on the edge where both are high, and rvld/rdat SHALL stay stable while rvld=1 and rrdy=0.
REQ-005 State machine: IDLE, WRITE, READ, DRAIN, DONE; cmd_rdy=1 only in IDLE.
REQ-006 IDLE, on accepted command with cmd_len=0: SHALL pulse done next cycle and remain IDLE.
REQ-007 IDLE, on accepted command with cmd_addr+cmd_len > SETS*DEPTH (33-bit sum, no wrap): SHALL pulse err next cycle, issue no access, and remain IDLE.
REQ-008 IDLE, on any other command: SHALL latch address and count, then enter WRITE (op=0) or READ (op=1).
REQ-009 WRITE: wrdy=1; a beat accepted at edge t SHALL appear at cycle t+1 as config_ce=1, config_we=1, config_address=current address, config_d0=beat, for exactly one cycle.
REQ-010 WRITE: the address SHALL increment per beat; after the last beat, enter DONE.
REQ-011 READ: a request (config_ce=1, config_we=0, registered outputs) SHALL be issued per cycle only while outstanding + FIFO occupancy < RB_DEPTH, so the FIFO never overflows.
REQ-012 The outstanding counter SHALL increment on issue and decrement on config_rack; simultaneous issue and rack SHALL leave it unchanged.
REQ-013 Every rack with outstanding > 0 SHALL push config_q0 into the readback FIFO, in order.
REQ-014 READ: after the last request, enter DRAIN; in DRAIN, when outstanding=0, enter DONE.
REQ-015 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-016 FIFO contents SHALL persist across commands, so a new command may start while rvld=1.
REQ-017 Simultaneous FIFO push and pop SHALL keep occupancy unchanged and lose no data.
REQ-018 config_rack with outstanding=0 SHALL be dropped and SHALL pulse err.
REQ-019 config_address and config_d0 are don't-care whenever config_ce=0.

Reset
REQ-020 While ap_rst_n=0 at an edge, the block SHALL, in the next cycle, be in state IDLE with cmd_rdy=1, wrdy=0, rvld=0, config_ce=0, config_we=0, busy=0, done=0, err=0, outstanding=0, FIFO empty, and config_address/config_d0/rdat=0.
REQ-021 Reset mid-command SHALL abort it with no done pulse; racks arriving afterwards SHALL be handled per REQ-018.

Verification
REQ-022 Write: op=0, addr=0, len=SETS*DEPTH, wdat=i with random wvld gaps -> exactly SETS*DEPTH config writes with address=i and d0=i, then one done pulse.
REQ-023 Read, 1-cycle rack latency, rrdy=1: op=1, addr=5, len=20 -> rdat=5..24 in order, outstanding never above RB_DEPTH, one done pulse.
REQ-024 Backpressure: op=1, len=64, rrdy=0 for 50 cycles -> at most RB_DEPTH requests issued and no further config_ce until rrdy rises; data complete and in order afterwards.
REQ-025 Rejects: len=0 -> done only; SETS=1, DEPTH=512, addr=510, len=3 -> err only, no config_ce; rack while idle -> err, FIFO unchanged.
REQ-026 Reset during READ with 3 requests outstanding -> IDLE, FIFO empty, no done; the 3 late racks produce 3 err pulses.
